joy_serial_reader: RTL and testbench

Parametrised serial joystick reader for UserIO shift-register adapters (74HC165-style chain), generalising the fixed two-player DB15 reader to 1–4 players and any per-player bit count, with a programmable shift clock and frame-level debounce. Sits in the `CLK_JOY` (40–50 MHz) domain of the emu top, drives `JOY_CLK`/`JOY_LOAD` to `USER_OUT` and samples `JOY_DATA` from `USER_IN`. Outputs active-high per-player button vectors that feed the core's joystick mux.

---
 rtl/joy_serial_reader.sv | 154 +++++++++++++++
 tb/tb_joy_serial_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
// joy_serial_reader: scans a 74HC165-style joystick chain on UserIO and
// debounces whole frames before presenting active-high button vectors.
module joy_serial_reader #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 4,
    parameter int DEBOUNCE = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_clk,
    output logic                      joy_load,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      frame_strobe
);

    localparam int N  = PLAYERS * BITS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
    localparam logic [3:0]    DEB     = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    raw_q, raw_d;
    logic [N-1:0]    cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    joy_q, joy_d;
    logic            strobe_q, strobe_d;
    logic            jclk_q, jclk_d;
    logic            jload_q, jload_d;
    logic            tick;
    logic [3:0]      cnt_n;

    assign tick = (div_q == DIV_MAX);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        raw_d    = raw_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        joy_d    = joy_q;
        strobe_d = 1'b0;
        cnt_n    = cnt_q;

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + DW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (enable) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (tick) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (tick) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (tick) begin
                    raw_d[idx_q] = ~joy_data;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tick) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_DONE: begin
                if (tick) begin
                    // a frame differing from the candidate restarts the count
                    if (raw_q == cand_q) begin
                        cnt_n = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
                    end else begin
                        cnt_n = 4'd1;
                    end
                    cand_d   = raw_q;
                    cnt_d    = cnt_n;
                    strobe_d = 1'b1;
                    if (cnt_n >= DEB) joy_d = raw_q;
                    idx_d = '0;
                    div_d = '0;
                    state_d = enable ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // pins follow the current state one clock later
        jclk_d  = (state_q == S_SHIFT);
        jload_d = (state_q != S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            idx_q    <= '0;
            raw_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            joy_q    <= '0;
            strobe_q <= 1'b0;
            jclk_q   <= 1'b0;
            jload_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            raw_q    <= raw_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            joy_q    <= joy_d;
            strobe_q <= strobe_d;
            jclk_q   <= jclk_d;
            jload_q  <= jload_d;
        end
    end

    assign joy_clk      = jclk_q;
    assign joy_load     = jload_q;
    assign joystick     = joy_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// tb_joy_serial_reader: directed checks of frame timing, pins, debounce,
// enable/reset behaviour and bit mapping against a serial chain model.
module tb_joy_serial_reader;

    localparam int NA = 24;
    localparam int NC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic en_a, en_b, en_c;
    logic jd_a, jd_b, jd_c;
    logic jc_a, jc_b, jc_c;
    logic jl_a, jl_b, jl_c;
    logic fs_a, fs_b, fs_c;
    logic [NA-1:0] js_a, js_b;
    logic [NC-1:0] js_c;
    logic [NA-1:0] pat_a, pat_b, sr_a, sr_b;
    logic [NC-1:0] pat_c, sr_c;

    int tests = 0;
    int fails = 0;

    joy_serial_reader #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .DEBOUNCE(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .joy_data(jd_a),
        .joy_clk(jc_a), .joy_load(jl_a), .joystick(js_a), .frame_strobe(fs_a)
    );

    joy_serial_reader #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .DEBOUNCE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .joy_data(jd_b),
        .joy_clk(jc_b), .joy_load(jl_b), .joystick(js_b), .frame_strobe(fs_b)
    );

    joy_serial_reader #(.PLAYERS(4), .BITS(16), .CLK_DIV(1), .DEBOUNCE(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(en_c), .joy_data(jd_c),
        .joy_clk(jc_c), .joy_load(jl_c), .joystick(js_c), .frame_strobe(fs_c)
    );

    // 74HC165 chain: parallel load while LOAD low, shift on clk rise,
    // pressed buttons pull the line low
    always @(posedge jc_a or negedge jl_a)
        if (!jl_a) sr_a <= ~pat_a;
        else       sr_a <= {1'b1, sr_a[NA-1:1]};
    always @(posedge jc_b or negedge jl_b)
        if (!jl_b) sr_b <= ~pat_b;
        else       sr_b <= {1'b1, sr_b[NA-1:1]};
    always @(posedge jc_c or negedge jl_c)
        if (!jl_c) sr_c <= ~pat_c;
        else       sr_c <= {1'b1, sr_c[NC-1:1]};

    assign jd_a = sr_a[0];
    assign jd_b = sr_b[0];
    assign jd_c = sr_c[0];

    task automatic wait_fs(input int which, input int limit, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && fs_a) || (which == 1 && fs_b) ||
                (which == 2 && fs_c)) return;
            n++;
            if (n > limit) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        pat_a = '0; pat_b = '0; pat_c = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({jc_a, jl_a, fs_a} !== 3'b010 || js_a !== '0) begin
            fails++;
            $display("FAIL reset_a: clk/load/strobe=%b%b%b js=%h, want 010 js=0",
                     jc_a, jl_a, fs_a, js_a);
        end
        tests++;
        if ({jc_b, jl_b, fs_b} !== 3'b010 || js_b !== '0) begin
            fails++;
            $display("FAIL reset_b: clk/load/strobe=%b%b%b js=%h, want 010 js=0",
                     jc_b, jl_b, fs_b, js_b);
        end
        tests++;
        if ({jc_c, jl_c, fs_c} !== 3'b010 || js_c !== '0) begin
            fails++;
            $display("FAIL reset_c: clk/load/strobe=%b%b%b js=%h, want 010 js=0",
                     jc_c, jl_c, fs_c, js_c);
        end
    endtask

    task automatic test_first_frame;
        int n;
        pat_a = 24'h800001;
        en_a  = 1'b1;
        wait_fs(0, 400, n);
        tests++;
        if (n !== 204) begin
            fails++;
            $display("FAIL first_strobe_time: got %0d, want 204", n);
        end
        tests++;
        if (js_a !== 24'h800001) begin
            fails++;
            $display("FAIL first_frame_js: got %h, want 800001", js_a);
        end
        pat_a = 24'h00F0A0;
        @(negedge clk);
        tests++;
        if (fs_a !== 1'b0) begin
            fails++;
            $display("FAIL strobe_width: got %b one clock later, want 0", fs_a);
        end
    endtask

    task automatic test_enable_drop;
        int n, strobes, bad;
        repeat (86) @(negedge clk);
        en_a = 1'b0;
        wait_fs(0, 300, n);
        tests++;
        if (n !== 116) begin
            fails++;
            $display("FAIL drop_strobe_time: got %0d, want 116", n);
        end
        tests++;
        if (js_a !== 24'h00F0A0) begin
            fails++;
            $display("FAIL drop_js: got %h, want 00f0a0", js_a);
        end
        repeat (2) @(negedge clk);
        strobes = 0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (fs_a) strobes++;
            if (jc_a !== 1'b0 || jl_a !== 1'b1) bad++;
        end
        tests++;
        if (strobes !== 0 || bad !== 0) begin
            fails++;
            $display("FAIL drop_idle: strobes=%0d bad_pins=%0d, want 0 0",
                     strobes, bad);
        end
    endtask

    task automatic test_pins;
        int low, first_low, pulses, badw, overlap, run, sk;
        logic prev;
        pat_b = '0;
        en_b  = 1'b1;
        low = 0; first_low = -1; pulses = 0; badw = 0;
        overlap = 0; run = 0; sk = -1; prev = 1'b0;
        for (int k = 0; k < 208; k++) begin
            @(negedge clk);
            if (k < 204 && !jl_b) begin
                low++;
                if (first_low < 0) first_low = k;
            end
            if (jc_b && !jl_b) overlap++;
            if (jc_b) run++;
            if (!jc_b && prev) begin
                pulses++;
                if (run != 4) badw++;
                run = 0;
            end
            prev = jc_b;
            if (fs_b && sk < 0) sk = k;
        end
        tests++;
        if (low !== 4 || first_low !== 1) begin
            fails++;
            $display("FAIL load_pulse: low=%0d first=%0d, want 4 1", low, first_low);
        end
        tests++;
        if (pulses !== 24 || badw !== 0) begin
            fails++;
            $display("FAIL clk_pulses: pulses=%0d bad_width=%0d, want 24 0",
                     pulses, badw);
        end
        tests++;
        if (overlap !== 0) begin
            fails++;
            $display("FAIL clk_during_load: got %0d, want 0", overlap);
        end
        tests++;
        if (sk !== 204) begin
            fails++;
            $display("FAIL pins_strobe_time: got %0d, want 204", sk);
        end
    endtask

    task automatic test_debounce;
        int n;
        wait_fs(1, 300, n);
        tests++;
        if (n !== 200 || js_b !== '0) begin
            fails++;
            $display("FAIL deb_settle: n=%0d js=%h, want 200 0", n, js_b);
        end
        pat_b = 24'h000010;
        wait_fs(1, 300, n);
        tests++;
        if (n !== 203 || js_b !== '0) begin
            fails++;
            $display("FAIL deb_glitch: n=%0d js=%h, want 203 0", n, js_b);
        end
        pat_b = '0;
        wait_fs(1, 300, n);
        tests++;
        if (js_b !== '0) begin
            fails++;
            $display("FAIL deb_after_glitch: got %h, want 0", js_b);
        end
        pat_b = 24'h0A0005;
        wait_fs(1, 300, n);
        tests++;
        if (js_b !== '0) begin
            fails++;
            $display("FAIL deb_press_f1: got %h, want 0", js_b);
        end
        wait_fs(1, 300, n);
        tests++;
        if (n !== 203 || js_b !== 24'h0A0005) begin
            fails++;
            $display("FAIL deb_press_f2: n=%0d js=%h, want 203 0a0005", n, js_b);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        repeat (54) @(negedge clk);
        tests++;
        if (jc_b !== 1'b1) begin
            fails++;
            $display("FAIL shift5_clk: got %b, want 1", jc_b);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tests++;
        if ({jc_b, jl_b, fs_b} !== 3'b010 || js_b !== '0) begin
            fails++;
            $display("FAIL mid_reset: clk/load/strobe=%b%b%b js=%h, want 010 js=0",
                     jc_b, jl_b, fs_b, js_b);
        end
        wait_fs(1, 400, n);
        tests++;
        if (n !== 204 || js_b !== '0) begin
            fails++;
            $display("FAIL restart_f1: n=%0d js=%h, want 204 0", n, js_b);
        end
        wait_fs(1, 300, n);
        tests++;
        if (js_b !== 24'h0A0005) begin
            fails++;
            $display("FAIL restart_f2: got %h, want 0a0005", js_b);
        end
    endtask

    task automatic test_walking;
        int n;
        int pos[7] = '{0, 1, 15, 16, 31, 48, 63};
        logic [NC-1:0] e;
        for (int i = 0; i < 7; i++) begin
            e = '0;
            e[pos[i]] = 1'b1;
            pat_c = e;
            en_c  = 1'b1;
            wait_fs(2, 300, n);
            tests++;
            if (n !== ((i == 0) ? 131 : 130)) begin
                fails++;
                $display("FAIL walk_len[%0d]: got %0d, want %0d",
                         pos[i], n, (i == 0) ? 131 : 130);
            end
            tests++;
            if (js_c !== e) begin
                fails++;
                $display("FAIL walk_bit[%0d]: got %h, want %h", pos[i], js_c, e);
            end
        end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_enable_drop();
        test_pins();
        test_debounce();
        test_mid_reset();
        test_walking();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
